// File: rtl/adc_spi_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adc_spi_capture: SPI master capture front end for a CPOL=0 serial ADC,   |
// | one-entry valid/ready output. Optional ADC_CAP_AVG_EN: block averaging.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adc_spi_capture #(
  parameter int DATA_W      = 12,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_BITS   = 4,
  parameter int CLK_DIV     = 4,
  parameter int CS_IDLE_CYC = 8,
  parameter int AVG_LOG2    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              ovr_clr,
  output logic              busy
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE_CYC) ? CLK_DIV : CS_IDLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_IDLE_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  busy_q, busy_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  logic                  frame_done;
  logic [DATA_W-1:0]     raw_sample;
  logic                  offer;
  logic [DATA_W-1:0]     offer_data;
  logic                  unused_bits;

  assign raw_sample = frame_q[FRAME_BITS-1-LEAD_BITS -: DATA_W];
  // Lead bits are shifted through but never consumed.
  assign unused_bits = ^{frame_q, (AVG_LOG2 > 0)};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    frame_d    = frame_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en || start) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            // ADC launches on the falling edge, so sdo is settled at the rise.
            sclk_d  = 1'b1;
            frame_d = {frame_q[FRAME_BITS-2:0], adc_sdo};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              bit_d      = '0;
              state_d    = S_HOLD;
              frame_done = 1'b1;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (en) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

`ifdef ADC_CAP_AVG_EN
  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int AVG_CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [AVG_CW-1:0] AVG_LAST = AVG_CW'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
  logic [AVG_CW-1:0] avg_cnt_q, avg_cnt_d;

  assign acc_sum = acc_q + ACC_W'(raw_sample);

  always_comb begin
    acc_d      = acc_q;
    avg_cnt_d  = avg_cnt_q;
    offer      = 1'b0;
    offer_data = acc_sum[AVG_LOG2 +: DATA_W];
    if (frame_done) begin
      if (avg_cnt_q == AVG_LAST) begin
        offer     = 1'b1;
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + AVG_CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  assign offer      = frame_done;
  assign offer_data = raw_sample;
`endif

  // One-entry holding register; an offer into a stalled full slot is lost.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (offer && (!valid_q || sample_ready)) begin
      data_d  = offer_data;
      valid_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (offer && valid_q && !sample_ready) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign busy         = busy_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule
`default_nettype wire

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- SPI master front end for an external serial ADC (ADCS7476-style: CPOL=0, data MSB-first, data launched on SCLK fall).
- Generates adc_cs_n/adc_sclk, shifts in one frame per conversion and extracts the DATA_W-bit sample.
- Presents the sample through a one-entry valid/ready holding register.
- Directly upstream of the sample pipeline registers: its sample_data/sample_valid feed the clock-enabled register stage.

Parameters:
- DATA_W, 12, sample width in bits.
- FRAME_BITS, 16, SCLK cycles per frame; must be >= LEAD_BITS+DATA_W.
- LEAD_BITS, 4, leading bits discarded before the sample MSB.
- CLK_DIV, 4, clk cycles per SCLK half-period; >= 1.
- CS_IDLE_CYC, 8, minimum clk cycles cs_n high between frames; >= 1.
- AVG_LOG2, 2, log2 of averaging depth; used only with ADC_CAP_AVG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  level; run frames back-to-back while high
- start  in  1  single-cycle pulse; one frame when idle
- adc_sdo  in  1  ADC serial data
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock, idle low
- sample_data  out  DATA_W  captured sample
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  consumer accepts sample this cycle
- overrun  out  1  sticky: a sample was dropped
- ovr_clr  in  1  clears overrun
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, sample_data=0, sample_valid=0, overrun=0, busy=0; FSM=IDLE; counters=0.
- Reset mid-frame: all of the above take effect on the next edge; any partial frame is discarded without output.
- All outputs are registered; there is no combinational path from input to output.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if en or start, go to SETUP with adc_cs_n=0. start while busy is ignored.
- SETUP: CLK_DIV cycles with cs_n low and sclk low, then SHIFT.
- SHIFT: FRAME_BITS periods, each CLK_DIV cycles sclk low then CLK_DIV cycles sclk high.
  - adc_sdo is shifted into the frame register on the clk edge that drives sclk 0->1.
  - On the edge that ends the final high phase, go to HOLD with sclk=0.
  - On that same edge, the extracted sample = frame bits [FRAME_BITS-1-LEAD_BITS : FRAME_BITS-LEAD_BITS-DATA_W] (MSB = first bit after the lead bits). It is offered to the output stage.
- HOLD: CLK_DIV cycles, then adc_cs_n=1 and go to GAP.
- GAP: CS_IDLE_CYC cycles. Then go to SETUP if en=1, else IDLE. A start pulse seen during GAP is dropped.
- cs_n low time = CLK_DIV*(2*FRAME_BITS+2) cycles. Back-to-back frame period = that + CS_IDLE_CYC.
- en deasserted mid-frame: the current frame completes normally and no further frames start.
- Output stage (one-entry):
  - Load when sample offered and (!sample_valid or sample_ready). sample_valid=1 from the next cycle.
  - Transfer when sample_valid and sample_ready. If no simultaneous load, sample_valid=0 next cycle.
  - Simultaneous transfer and load: the new sample loads and sample_valid stays 1.
  - Offer while sample_valid and !sample_ready: the new sample is dropped, sample_data is unchanged, and overrun=1 next cycle.
  - ovr_clr clears overrun. If ovr_clr and a new overrun occur in the same cycle, the overrun wins.
  - sample_data is stable while sample_valid and !sample_ready.

Optional Feature:
- Macro: ADC_CAP_AVG_EN.
- Defined:
  - Extracted samples accumulate in an accumulator of width DATA_W+AVG_LOG2.
  - Every 2^AVG_LOG2 frames, the value accumulator>>AVG_LOG2 (truncated) is offered to the output stage and the accumulator clears.
  - Intermediate frames offer nothing.
  - Overrun rules apply to averaged outputs only.
  - Reset clears the accumulator and frame count.
- Undefined: every frame offers its raw sample, and no accumulator logic is synthesized.

Test Plan:
- Defaults except CLK_DIV=2. ADC model returns frame 0x0ABC; start pulse, sample_ready=1.
  - Required: exactly 16 sclk rising edges; cs_n low 68 cycles; sample_data=0xABC with a one-cycle sample_valid pulse; busy falls after 68+8 cycles.
- en=1 for 3 frames, ADC returns 0x0123, 0x0456, 0x0789, sample_ready=1.
  - Required: three valids, 76 cycles apart, in that order; cs_n high exactly 8 cycles between frames.
- en=1, sample_ready=0 through 2 frames (0x0111, 0x0222).
  - Required: sample_data stays 0x111, overrun=1 after frame 2.
  - Then ready=1 + ovr_clr pulse: valid drops next cycle and overrun=0.
- Ready asserted on the exact cycle the frame-2 sample is offered.
  - Required: frame-1 sample transfers, 0x222 loads, sample_valid stays continuously 1, overrun stays 0.
- rst asserted at sclk edge 7 of a frame.
  - Required: next cycle cs_n=1, sclk=0, valid=0, busy=0. A new start yields a clean full 16-edge frame.
- With ADC_CAP_AVG_EN, AVG_LOG2=2, ADC returns 0x100, 0x101, 0x102, 0x103.
  - Required: single output 0x101 after frame 4, none before.
